fork_join_ctrl: RTL and testbench
=================================

# fork_join_ctrl

Hardware fork/join scheduler for the process-control datapath. On one `start` it launches up to `NUM_JOBS` worker engines in parallel. It then reports join completion under one of three policies: all, any, or none, mirroring `join`, `join_any` and `join_none`. It also tracks the remaining jobs to a drain (the `wait fork` equivalent) and can abort them (the `disable fork` equivalent). It sits between the sequencing master and the worker bank.

## Interface
Parameters:
- `NUM_JOBS`, 4: number of worker slots, range 1..16.
- `TIMEOUT_CYC`, 1000: watchdog limit in cycles. Used only with `FJ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request, one-cycle pulse, sampled in IDLE only.
- `job_mask`  in  NUM_JOBS  jobs to launch, sampled with `start`.
- `mode`  in  2  join policy, sampled with `start`: 0 = ALL, 1 = ANY, 2 = NONE, 3 = reserved (treated as ALL).
- `kill`  in  1  abort all pending jobs.
- `job_done`  in  NUM_JOBS  per-job completion pulses from the workers.
- `job_go`  out  NUM_JOBS  per-job launch pulses.
- `job_kill`  out  NUM_JOBS  per-job abort pulses.
- `pending`  out  NUM_JOBS  jobs launched and not yet finished or killed.
- `busy`  out  1  high whenever the state is not IDLE.
- `join_done`  out  1  one-cycle pulse when the join policy is satisfied.
- `all_done`  out  1  one-cycle pulse when every launched job has finished.
- `first_id`  out  $clog2(NUM_JOBS) (minimum 1)  index of the first finisher, valid from the ANY `join_done` pulse until the next `start`.
- `killed`  out  1  one-cycle pulse when an abort completes.
- `timeout`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States are IDLE, LAUNCH, JOIN_WAIT, DRAIN.
- **IDLE**
  - `start` with a nonzero mask: latch `job_mask` and `mode`, then go to LAUNCH.
  - `start` with a zero mask: pulse `join_done` and `all_done` on the next cycle and stay in IDLE (empty fork).
  - `start` in any other state is ignored.
- **LAUNCH** (one cycle)
  - Drive `job_go` = mask and load `pending` = mask.
  - Mode NONE: `join_done` pulses in this same cycle; next state is DRAIN.
  - Mode ALL or ANY: next state is JOIN_WAIT.
  - `job_done` is ignored in this cycle.
- **Done handling** (JOIN_WAIT and DRAIN)
  - Each cycle, `pending` <= `pending` & ~`job_done`.
  - `job_done` bits for non-pending jobs are ignored.
- **JOIN_WAIT, mode ALL**: when `pending` reaches 0, pulse `join_done` and `all_done` together and return to IDLE.
- **JOIN_WAIT, mode ANY**
  - On the first cycle with any valid done bit, pulse `join_done` and set `first_id` to the lowest set index among the simultaneous done bits.
  - If `pending` is then 0, also pulse `all_done` and return to IDLE. Otherwise go to DRAIN.
- **DRAIN**: when `pending` reaches 0, pulse `all_done` and return to IDLE.
- **Kill** (JOIN_WAIT or DRAIN)
  - Kill has priority over same-cycle done bits.
  - `job_kill` = `pending` & ~`job_done` for one cycle, `pending` is cleared, `killed` pulses, and the state returns to IDLE.
  - No `join_done` or `all_done` pulse in that cycle.
  - `kill` in IDLE or LAUNCH is ignored.

## Timing
- Every output is registered.
- Reset values: every output is 0 and the state is IDLE.
- Reset during operation drops all state and pending work immediately. `job_kill` is not pulsed.
- Latencies:
  - `start` at edge t: `job_go` is high in cycle t+1.
  - Earliest accepted `job_done` is in cycle t+2.
  - `job_done` sampled at edge u: resulting `pending`, `join_done`, `all_done` and `killed` are visible in cycle u+1.
- Back-to-back launches: a new `start` is accepted in the first IDLE cycle after `all_done` or `killed`.
- `busy` falls in the same cycle that `all_done` or `killed` pulses.

## Configuration
- `FJ_TIMEOUT_EN` defined:
  - A cycle counter of width $clog2(TIMEOUT_CYC+1) clears in LAUNCH and increments in JOIN_WAIT and DRAIN.
  - When the count equals `TIMEOUT_CYC` with `pending` nonzero, the block performs the kill sequence and pulses `timeout` together with `killed`.
  - An external `kill` in the same cycle gives identical outputs plus `timeout`.
- `FJ_TIMEOUT_EN` undefined: no counter is built and `timeout` is tied to 0.

## Test plan
- ALL, mask 0111, done pulses on jobs 1, 0, 2 at 5, 10 and 15 cycles after `job_go` -> `pending` steps 0101, 0100, 0000; a single `join_done` together with `all_done` in the cycle after the job 2 done.
- ANY, mask 0111, jobs 0, 1, 2 done at +12, +3, +6 -> `join_done` after the +3 done with `first_id`=1; `all_done` after the +12 done; exactly one `join_done`.
- NONE, mask 0011 -> `join_done` in the `job_go` cycle; `kill` at +5 with job 0 done in the same cycle -> `job_kill`=0010, `killed` pulse, no `all_done`, back in IDLE.
- ANY with done bits 1 and 3 simultaneous, mask 1010 -> `first_id`=1, `join_done` and `all_done` in the same cycle.
- `start` with mask 0000 -> `join_done` and `all_done` next cycle, no `job_go`; `start` while busy -> ignored, `job_go` unchanged.
- With `FJ_TIMEOUT_EN` and `TIMEOUT_CYC`=20, mask 0001, no done -> `job_kill`=0001 with `timeout` and `killed` pulsing together. Then assert `rst_n` low mid-run -> all outputs 0 at once.

Source files
------------

// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl
//   Fork/join scheduler between the sequencing master and the worker bank.
//   One start launches up to NUM_JOBS workers in parallel. Join completion is
//   then reported under an ALL, ANY or NONE policy. The block tracks the
//   remaining jobs to a drain and can abort everything still outstanding.
//
//   Optional feature: define FJ_TIMEOUT_EN to build a watchdog. The watchdog
//   kills the outstanding jobs after TIMEOUT_CYC cycles in JOIN_WAIT/DRAIN.
//
// Parameters
//   NUM_JOBS     number of worker slots (1..16)
//   TIMEOUT_CYC  watchdog limit in cycles (FJ_TIMEOUT_EN only)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      launch request, sampled in IDLE only
//   job_mask   jobs to launch, sampled with start
//   mode       join policy: 0 ALL, 1 ANY, 2 NONE, 3 treated as ALL
//   kill       abort all pending jobs (JOIN_WAIT / DRAIN only)
//   job_done   per-job completion pulses from the workers
//   job_go     per-job launch pulses
//   job_kill   per-job abort pulses
//   pending    jobs launched and not yet finished or killed
//   busy       state is not IDLE
//   join_done  pulse when the join policy is satisfied
//   all_done   pulse when every launched job has finished
//   first_id   lowest index among the first finishers (ANY policy)
//   killed     pulse when an abort completes
//   timeout    pulse on watchdog expiry (0 unless FJ_TIMEOUT_EN)
module fork_join_ctrl #(
    parameter int  NUM_JOBS    = 4,
    parameter int  TIMEOUT_CYC = 1000,
    localparam int ID_W        = (NUM_JOBS > 1) ? $clog2(NUM_JOBS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_JOBS-1:0] job_mask,
    input  logic [1:0]          mode,
    input  logic                kill,
    input  logic [NUM_JOBS-1:0] job_done,
    output logic [NUM_JOBS-1:0] job_go,
    output logic [NUM_JOBS-1:0] job_kill,
    output logic [NUM_JOBS-1:0] pending,
    output logic                busy,
    output logic                join_done,
    output logic                all_done,
    output logic [ID_W-1:0]     first_id,
    output logic                killed,
    output logic                timeout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_JOIN_WAIT = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ANY  = 2'd1;
    localparam logic [1:0] MODE_NONE = 2'd2;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [NUM_JOBS-1:0] pending_d, go_d, kill_d;
    logic [NUM_JOBS-1:0] valid_done, remain;
    logic                join_d, all_d, killed_d, to_d, busy_d;
    logic [ID_W-1:0]     first_d, lowest_id;
    logic                to_hit;
    logic                active;

    assign active     = (state_q == S_JOIN_WAIT) || (state_q == S_DRAIN);
    assign valid_done = pending & job_done;
    assign remain     = pending & ~job_done;

    // Lowest set index among this cycle's valid done bits.
    always_comb begin
        lowest_id = '0;
        for (int i = NUM_JOBS - 1; i >= 0; i--) begin
            if (valid_done[i]) lowest_id = ID_W'(i);
        end
    end

`ifdef FJ_TIMEOUT_EN
    localparam int                CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q;

    // The count cannot run past CNT_LIMIT: reaching it forces the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt_q <= '0;
        else if (state_q == S_LAUNCH) cnt_q <= '0;
        else if (active)            cnt_q <= cnt_q + 1'b1;
    end

    assign to_hit = active && (cnt_q == CNT_LIMIT) && (|pending);
`else
    // Watchdog not built; this is constant 0 for any legal TIMEOUT_CYC.
    assign to_hit = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pending_d = pending;
        go_d      = '0;
        kill_d    = '0;
        join_d    = 1'b0;
        all_d     = 1'b0;
        killed_d  = 1'b0;
        to_d      = 1'b0;
        first_d   = first_id;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (|job_mask) begin
                        state_d   = S_LAUNCH;
                        mode_d    = mode;
                        go_d      = job_mask;
                        pending_d = job_mask;
                        // NONE joins in the job_go cycle itself.
                        join_d    = (mode == MODE_NONE);
                    end else begin
                        join_d = 1'b1;
                        all_d  = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = (mode_q == MODE_NONE) ? S_DRAIN : S_JOIN_WAIT;
            end
            default: begin
                if (kill || to_hit) begin
                    // Abort wins over done bits arriving in the same cycle.
                    kill_d    = remain;
                    pending_d = '0;
                    killed_d  = 1'b1;
                    to_d      = to_hit;
                    state_d   = S_IDLE;
                end else begin
                    pending_d = remain;
                    if (state_q == S_JOIN_WAIT && mode_q == MODE_ANY) begin
                        if (|valid_done) begin
                            join_d  = 1'b1;
                            first_d = lowest_id;
                            if (remain == '0) begin
                                all_d   = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_DRAIN;
                            end
                        end
                    end else if (remain == '0) begin
                        join_d  = (state_q == S_JOIN_WAIT);
                        all_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            pending   <= '0;
            job_go    <= '0;
            job_kill  <= '0;
            busy      <= 1'b0;
            join_done <= 1'b0;
            all_done  <= 1'b0;
            first_id  <= '0;
            killed    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pending   <= pending_d;
            job_go    <= go_d;
            job_kill  <= kill_d;
            busy      <= busy_d;
            join_done <= join_d;
            all_done  <= all_d;
            first_id  <= first_d;
            killed    <= killed_d;
            timeout   <= to_d;
        end
    end

endmodule

// File: tb/tb_fork_join_ctrl.sv
module tb_fork_join_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] job_mask;
    logic [1:0] mode;
    logic       kill;
    logic [3:0] job_done;
    logic [3:0] job_go;
    logic [3:0] job_kill;
    logic [3:0] pending;
    logic       busy;
    logic       join_done;
    logic       all_done;
    logic [1:0] first_id;
    logic       killed;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    fork_join_ctrl #(
        .NUM_JOBS    (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .job_mask  (job_mask),
        .mode      (mode),
        .kill      (kill),
        .job_done  (job_done),
        .job_go    (job_go),
        .job_kill  (job_kill),
        .pending   (pending),
        .busy      (busy),
        .join_done (join_done),
        .all_done  (all_done),
        .first_id  (first_id),
        .killed    (killed),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit act=running req=finished");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic       start;
        logic [3:0] mask;
        logic [1:0] mode;
        logic       kill;
        logic [3:0] done;
        logic [3:0] e_go;
        logic [3:0] e_kill;
        logic [3:0] e_pend;
        logic       e_busy;
        logic       e_join;
        logic       e_all;
        logic       e_killed;
        logic [1:0] e_first;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start    = 1'b0;
        job_mask = '0;
        mode     = '0;
        kill     = 1'b0;
        job_done = '0;
    endtask

    // n quiet cycles in which no join/all pulse may appear.
    task automatic idle_n(input string nm, input int n);
        idle_in();
        for (int k = 0; k < n; k++) begin
            tick();
            chk({nm, " quiet join"}, 32'(join_done), 32'd0);
            chk({nm, " quiet all"}, 32'(all_done), 32'd0);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " go"},      32'(job_go),    32'd0);
        chk({nm, " kill"},    32'(job_kill),  32'd0);
        chk({nm, " pend"},    32'(pending),   32'd0);
        chk({nm, " busy"},    32'(busy),      32'd0);
        chk({nm, " join"},    32'(join_done), 32'd0);
        chk({nm, " all"},     32'(all_done),  32'd0);
        chk({nm, " first"},   32'(first_id),  32'd0);
        chk({nm, " killed"},  32'(killed),    32'd0);
        chk({nm, " timeout"}, 32'(timeout),   32'd0);
    endtask

    initial begin
        // Columns: start mask mode kill done | go jkill pend busy join all killed first
        vecs[0]  = '{1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 4'b0011, 2'd2, 1'b0, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 4'b1111, 2'd0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 4'b1100, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{1'b0, 4'b0000, 2'd0, 1'b1, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 4'b1010, 2'd1, 1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 4'b0000, 2'd0, 1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        vecs[13] = '{1'b0, 4'b0000, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};

        rst_n = 1'b0;
        idle_in();
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Empty fork, NONE with kill + same-cycle done, ignored start/kill, ANY simultaneous
        for (int i = 0; i < 14; i++) begin
            start    = vecs[i].start;
            job_mask = vecs[i].mask;
            mode     = vecs[i].mode;
            kill     = vecs[i].kill;
            job_done = vecs[i].done;
            tick();
            chk($sformatf("row%0d go", i),      32'(job_go),    32'(vecs[i].e_go));
            chk($sformatf("row%0d kill", i),    32'(job_kill),  32'(vecs[i].e_kill));
            chk($sformatf("row%0d pend", i),    32'(pending),   32'(vecs[i].e_pend));
            chk($sformatf("row%0d busy", i),    32'(busy),      32'(vecs[i].e_busy));
            chk($sformatf("row%0d join", i),    32'(join_done), 32'(vecs[i].e_join));
            chk($sformatf("row%0d all", i),     32'(all_done),  32'(vecs[i].e_all));
            chk($sformatf("row%0d killed", i),  32'(killed),    32'(vecs[i].e_killed));
            chk($sformatf("row%0d first", i),   32'(first_id),  32'(vecs[i].e_first));
            chk($sformatf("row%0d timeout", i), 32'(timeout),   32'd0);
        end

        // ALL, mask 0111: done 1 @+5, 0 @+10, 2 @+15
        idle_in();
        start = 1'b1; job_mask = 4'b0111; mode = 2'd0;
        tick();
        chk("all_go", 32'(job_go), 32'h7);
        idle_n("all_a", 5);
        job_done = 4'b0010;
        tick();
        chk("all_pend1", 32'(pending), 32'h5);
        chk("all_join1", 32'(join_done), 32'd0);
        idle_n("all_b", 4);
        job_done = 4'b0001;
        tick();
        chk("all_pend2", 32'(pending), 32'h4);
        chk("all_join2", 32'(join_done), 32'd0);
        idle_n("all_c", 4);
        job_done = 4'b0100;
        tick();
        chk("all_pend3", 32'(pending), 32'h0);
        chk("all_join3", 32'(join_done), 32'd1);
        chk("all_all3", 32'(all_done), 32'd1);
        chk("all_busy3", 32'(busy), 32'd0);
        idle_n("all_d", 2);

        // ANY, mask 0111: job1 @+3, job2 @+6, job0 @+12
        start = 1'b1; job_mask = 4'b0111; mode = 2'd1;
        tick();
        chk("any_go", 32'(job_go), 32'h7);
        idle_n("any_a", 3);
        job_done = 4'b0010;
        tick();
        chk("any_join1", 32'(join_done), 32'd1);
        chk("any_first", 32'(first_id), 32'd1);
        chk("any_all1", 32'(all_done), 32'd0);
        chk("any_pend1", 32'(pending), 32'h5);
        chk("any_busy1", 32'(busy), 32'd1);
        idle_n("any_b", 2);
        job_done = 4'b0100;
        tick();
        chk("any_pend2", 32'(pending), 32'h1);
        chk("any_join2", 32'(join_done), 32'd0);
        idle_n("any_c", 5);
        job_done = 4'b0001;
        tick();
        chk("any_all3", 32'(all_done), 32'd1);
        chk("any_join3", 32'(join_done), 32'd0);
        chk("any_busy3", 32'(busy), 32'd0);
        chk("any_first3", 32'(first_id), 32'd1);
        idle_n("any_d", 2);

`ifdef FJ_TIMEOUT_EN
        // Watchdog: mask 0001, no done ever arrives
        start = 1'b1; job_mask = 4'b0001; mode = 2'd0;
        tick();
        idle_in();
        for (int k = 0; k < 100 && !killed; k++) tick();
        chk("to_killed", 32'(killed), 32'd1);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_jkill", 32'(job_kill), 32'h1);
        chk("to_all", 32'(all_done), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        tick();
`endif

        // Reset mid-run: outputs drop without waiting for a clock edge
        start = 1'b1; job_mask = 4'b1111; mode = 2'd0;
        tick();
        idle_in();
        chk("mid_go_pre", 32'(job_go), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_pend", 32'(pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
